up_down_bounded_counter: RTL
============================

Name: up_down_bounded_counter

Overview:
Parametrised successor to the team's basic up/down/load counter. Adds runtime-programmable lower and upper bounds, a programmable step size, and a per-cycle choice of wrap or saturate at the bounds. Adds boundary-status outputs and a registered boundary-event pulse. Used as a general-purpose sequencer or index counter wherever a plain modulo-2^N count is not enough.

Parameters:
N, 8, counter width in bits (N >= 2).
RESET_VAL, 0, value Q takes on reset, independent of the bounds.

Ports:
clk  input  1  clock; all state updates on its rising edge.
reset_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
en  input  1  count enable.
up  input  1  direction: 1 = count up, 0 = count down.
load  input  1  parallel load request.
D  input  N  load value.
min_val  input  N  lower bound, inclusive.
max_val  input  N  upper bound, inclusive.
step  input  N  increment/decrement magnitude.
sat  input  1  boundary mode: 1 = saturate, 0 = wrap to the opposite bound.
Q  output  N  count value, registered.
at_max  output  1  combinational: Q == max_val.
at_min  output  1  combinational: Q == min_val.
bound_evt  output  1  registered one-cycle pulse marking a boundary crossing or clamp.
cfg_err  output  1  combinational: min_val > max_val.

Behaviour:
- Priority on each rising clk edge: reset_n low > cfg_err > load > en > hold.
- Reset (reset_n = 0): Q <= RESET_VAL, bound_evt <= 0. Applies mid-count and overrides load and en in the same cycle.
- cfg_err = 1: Q holds and bound_evt <= 0, even if load or en is high.
- Load: Q <= D if min_val <= D <= max_val.
  - D > max_val: Q <= max_val, bound_evt <= 1.
  - D < min_val: Q <= min_val, bound_evt <= 1.
  - A load ignores en and up.
- Count up (en = 1, up = 1): compute sum = Q + step in N+1 bits, with no truncation.
  - sum <= max_val: Q <= sum[N-1:0], bound_evt <= 0.
  - sum > max_val and sat = 1: Q <= max_val, bound_evt <= 1.
  - sum > max_val and sat = 0: Q <= min_val, bound_evt <= 1.
- Count down (en = 1, up = 0): compute diff = {1'b0,Q} - {1'b0,step} in N+1 bits, signed.
  - diff >= min_val (and no borrow): Q <= diff[N-1:0], bound_evt <= 0.
  - Otherwise, sat = 1: Q <= min_val, bound_evt <= 1.
  - Otherwise, sat = 0: Q <= max_val, bound_evt <= 1.
- step = 0 while enabled: Q holds, bound_evt <= 0.
- Q already outside [min_val, max_val] (bounds changed at runtime): the next enabled count uses the same comparisons.
  - Example: counting up with Q > max_val → boundary event.
  - No correction is applied without en or load.
- Repeated saturation: bound_evt pulses on every enabled cycle that attempts to pass the bound, including when Q already equals that bound.
- Hold (en = 0, load = 0): Q unchanged, bound_evt <= 0.
- Latency: Q reflects a load or count one clock after the request edge. bound_evt is aligned with that same Q update.
- at_max, at_min and cfg_err are combinational from Q and the bound inputs, with no latency.

Optional Feature:
Macro: UDB_STICKY_OVF_EN.
- Defined: adds input clr_ovf (1 bit) and output ovf_sticky (1 bit, registered).
  - ovf_sticky is set on any cycle that sets bound_evt.
  - It is cleared by reset or by clr_ovf = 1.
  - If set and clear occur in the same cycle, set wins.
- Not defined: both ports are absent. No extra logic is generated.

Test Plan:
(All scenarios use N=4, RESET_VAL=0, min_val=2, max_val=12, step=3.)
1. Reset: reset_n=0 for one edge with en=1, load=1 → Q=0, bound_evt=0. Release reset_n; with en=0, Q stays 0.
2. Up wrap (sat=0): load D=6, then en=1, up=1 → Q sequence 6,9,12,2,5. bound_evt high only in the cycle Q becomes 2. at_max=1 while Q=12.
3. Up saturate (sat=1): load D=9, en=1, up=1 → Q = 9,12,12,12. bound_evt=0 at 12 first reached, then 1 on each following cycle.
4. Down count:
   - sat=0: load D=4, en=1, up=0 → Q = 4,12,9,6,3,12, with bound_evt on each wrap to 12.
   - Repeat with sat=1 → Q = 4,2,2, with bound_evt on both clamped cycles.
5. Load clamp and priority: load=1, en=1, D=14 → Q=12, bound_evt=1. Then D=1 → Q=2, bound_evt=1. Then load=1, reset_n=0 → Q=0.
6. Config error and sticky flag:
   - Set min_val=10, max_val=5 with en=1 → cfg_err=1 and Q frozen for 3 cycles.
   - With UDB_STICKY_OVF_EN: ovf_sticky stays 1 after scenario 2's wrap until clr_ovf is pulsed.

Source files
------------

// File: rtl/up_down_bounded_counter.sv
// -----------------------------------------------------------------------------
// up_down_bounded_counter
//
// General-purpose up/down counter with runtime-programmable inclusive bounds,
// a programmable step, and a per-cycle choice of wrap or saturate at the
// bounds. Successor to the plain up/down/load counter, intended for sequencers
// and index counters that need something other than a modulo-2^N count.
//
// Parameters
//   N          counter width in bits (N >= 2)
//   RESET_VAL  value Q takes on reset, independent of the bounds
//
// Ports
//   clk        in   1  clock, rising-edge active
//   reset_n    in   1  synchronous active-low reset
//   en         in   1  count enable
//   up         in   1  direction: 1 = up, 0 = down
//   load       in   1  parallel load request (takes priority over en)
//   D          in   N  load value, clamped into [min_val, max_val]
//   min_val    in   N  lower bound, inclusive
//   max_val    in   N  upper bound, inclusive
//   step       in   N  increment/decrement magnitude
//   sat        in   1  1 = saturate at the bound, 0 = wrap to the opposite bound
//   Q          out  N  registered count
//   at_max     out  1  combinational, Q == max_val
//   at_min     out  1  combinational, Q == min_val
//   bound_evt  out  1  registered pulse, aligned with the Q update that
//                      clamped or wrapped
//   cfg_err    out  1  combinational, min_val > max_val
//
// Optional feature (macro UDB_STICKY_OVF_EN)
//   clr_ovf    in   1  clears ovf_sticky (a same-cycle set wins)
//   ovf_sticky out  1  registered, set whenever bound_evt is set
//
// Update priority each edge: reset > cfg_err > load > en > hold.
// -----------------------------------------------------------------------------
module up_down_bounded_counter #(
  parameter int           N         = 8,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] D,
  input  logic [N-1:0] min_val,
  input  logic [N-1:0] max_val,
  input  logic [N-1:0] step,
  input  logic         sat,
  output logic [N-1:0] Q,
  output logic         at_max,
  output logic         at_min,
  output logic         bound_evt,
  output logic         cfg_err
`ifdef UDB_STICKY_OVF_EN
  ,
  input  logic         clr_ovf,
  output logic         ovf_sticky
`endif
);

  // Result of one candidate update: the next count and whether it hit a bound.
  typedef struct packed {
    logic [N-1:0] q;
    logic         evt;
  } upd_t;

  // Up count. The sum is formed one bit wider so a carry out of N bits is
  // treated as "past the upper bound" rather than silently wrapping.
  function automatic upd_t f_count_up(
    input logic [N-1:0] q_i,
    input logic [N-1:0] step_i,
    input logic [N-1:0] lo_i,
    input logic [N-1:0] hi_i,
    input logic         sat_i
  );
    logic [N:0] sum;
    upd_t       res;
    sum = {1'b0, q_i} + {1'b0, step_i};
    if (sum <= {1'b0, hi_i}) begin
      res.q   = sum[N-1:0];
      res.evt = 1'b0;
    end else begin
      res.q   = sat_i ? hi_i : lo_i;
      res.evt = 1'b1;
    end
    return res;
  endfunction

  // Down count. The difference is signed and one bit wider, so a borrow
  // shows up as a negative value and always fails the lower-bound test.
  function automatic upd_t f_count_down(
    input logic [N-1:0] q_i,
    input logic [N-1:0] step_i,
    input logic [N-1:0] lo_i,
    input logic [N-1:0] hi_i,
    input logic         sat_i
  );
    logic signed [N:0] diff;
    upd_t              res;
    diff = $signed({1'b0, q_i}) - $signed({1'b0, step_i});
    if (diff >= $signed({1'b0, lo_i})) begin
      res.q   = diff[N-1:0];
      res.evt = 1'b0;
    end else begin
      res.q   = sat_i ? lo_i : hi_i;
      res.evt = 1'b1;
    end
    return res;
  endfunction

  // Load with clamping into the programmed window.
  function automatic upd_t f_clamp_load(
    input logic [N-1:0] d_i,
    input logic [N-1:0] lo_i,
    input logic [N-1:0] hi_i
  );
    upd_t res;
    if (d_i > hi_i) begin
      res.q   = hi_i;
      res.evt = 1'b1;
    end else if (d_i < lo_i) begin
      res.q   = lo_i;
      res.evt = 1'b1;
    end else begin
      res.q   = d_i;
      res.evt = 1'b0;
    end
    return res;
  endfunction

  logic [N-1:0] r_q;
  logic         r_bound_evt;

  logic         w_cfg_err;
  logic         w_step_zero;
  upd_t         w_up_res;
  upd_t         w_dn_res;
  upd_t         w_ld_res;
  logic [N-1:0] w_q_nxt;
  logic         w_evt_nxt;

  assign w_cfg_err   = (min_val > max_val);
  assign w_step_zero = (step == '0);

  assign w_up_res = f_count_up  (r_q, step, min_val, max_val, sat);
  assign w_dn_res = f_count_down(r_q, step, min_val, max_val, sat);
  assign w_ld_res = f_clamp_load(D, min_val, max_val);

  // Next-state selection. A zero step is an explicit hold so that a count
  // sitting outside the window is not reported as a boundary event.
  always_comb begin
    w_q_nxt   = r_q;
    w_evt_nxt = 1'b0;
    if (w_cfg_err) begin
      w_q_nxt   = r_q;
      w_evt_nxt = 1'b0;
    end else if (load) begin
      w_q_nxt   = w_ld_res.q;
      w_evt_nxt = w_ld_res.evt;
    end else if (en && !w_step_zero) begin
      if (up) begin
        w_q_nxt   = w_up_res.q;
        w_evt_nxt = w_up_res.evt;
      end else begin
        w_q_nxt   = w_dn_res.q;
        w_evt_nxt = w_dn_res.evt;
      end
    end
  end

  // Registered count and boundary pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_q         <= RESET_VAL;
      r_bound_evt <= 1'b0;
    end else begin
      r_q         <= w_q_nxt;
      r_bound_evt <= w_evt_nxt;
    end
  end

`ifdef UDB_STICKY_OVF_EN
  logic r_ovf_sticky;

  // Set has priority over clear so an event in the clearing cycle is kept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ovf_sticky <= 1'b0;
    end else if (w_evt_nxt) begin
      r_ovf_sticky <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf_sticky <= 1'b0;
    end
  end

  assign ovf_sticky = r_ovf_sticky;
`endif

  assign Q         = r_q;
  assign bound_evt = r_bound_evt;
  assign at_max    = (r_q == max_val);
  assign at_min    = (r_q == min_val);
  assign cfg_err   = w_cfg_err;

endmodule
